// File: rtl/mcpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_pkg
//  Description : Shared opcode constants, instruction-class enum and the
//                instruction classifier for the mcpu_core_p accumulator CPU.
//  Revision    : 1.0  initial release
// ============================================================================
package mcpu_pkg;

    // Opcode fields, compared against the leading bits of instr[5:0]
    localparam logic [1:0] OP_JCC = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_LDA = 3'b110;
    localparam logic [5:0] OP_NOT = 6'b111000;
    localparam logic [5:0] OP_OUT = 6'b111001;
    localparam logic [5:0] OP_SEG = 6'b111010;

    typedef enum logic [3:0] {
        IC_JCC = 4'd0,
        IC_LDI = 4'd1,
        IC_ADD = 4'd2,
        IC_STA = 4'd3,
        IC_LDA = 4'd4,
        IC_NOT = 4'd5,
        IC_OUT = 4'd6,
        IC_SEG = 4'd7,
        IC_NOP = 4'd8
    } iclass_e;

    // Every one of the 64 encodings maps to a class; unassigned 111xxx
    // patterns fall through to NOP.
    function automatic iclass_e decode_class(input logic [5:0] instr);
        iclass_e cls;
        cls = IC_NOP;
        if (instr[5:4] == OP_JCC)      cls = IC_JCC;
        else if (instr[5:4] == OP_LDI) cls = IC_LDI;
        else if (instr[5:3] == OP_ADD) cls = IC_ADD;
        else if (instr[5:3] == OP_STA) cls = IC_STA;
        else if (instr[5:3] == OP_LDA) cls = IC_LDA;
        else if (instr == OP_NOT)      cls = IC_NOT;
        else if (instr == OP_OUT)      cls = IC_OUT;
        else if (instr == OP_SEG)      cls = IC_SEG;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcpu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_regfile
//  Description : Register file with one combinational read port and one
//                synchronous write port. Only NREGS of the 8 addressable
//                registers exist: reads above that return 0, writes are
//                dropped.
//  Ports       : clk, rst      clock / synchronous active-high clear
//                i_raddr       read index (3 bits)
//                o_rdata       read data (combinational)
//                i_we          write enable
//                i_waddr       write index (3 bits)
//                i_wdata       write data
//  Revision    : 1.0  initial release
// ============================================================================
module mcpu_regfile #(
    parameter int DW    = 8,
    parameter int NREGS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    i_raddr,
    output logic [DW-1:0] o_rdata,
    input  logic          i_we,
    input  logic [2:0]    i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_regs [NREGS];

    // Full 3-bit address compare per implemented register, so an
    // out-of-range index never aliases onto a low register.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NREGS; k++) begin
            if (rst) begin
                r_regs[k] <= '0;
            end else if (i_we && (i_waddr == 3'(k))) begin
                r_regs[k] <= i_wdata;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (i_raddr == 3'(k)) begin
                o_rdata = r_regs[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcpu_core_p.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_core_p
//  Description : Parametrised single-cycle accumulator CPU core. One 6-bit
//                instruction per cycle is presented against pc; instr_valid
//                low stalls all state.
//  Ports       : clk, rst      clock / synchronous active-high reset
//                instr         instruction for the current pc
//                instr_valid   1 = execute instr this edge, 0 = stall
//                pc            program counter
//                accu, carry   accumulator and carry flag
//                out_data      value latched by OUT
//                out_strobe    one-cycle pulse after each executed OUT
//  Revision    : 1.0  initial release
// ============================================================================
module mcpu_core_p
    import mcpu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int PCW   = 8,
    parameter int NREGS = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [5:0]     instr,
    input  logic           instr_valid,
    output logic [PCW-1:0] pc,
    output logic [DW-1:0]  accu,
    output logic           carry,
    output logic [DW-1:0]  out_data,
    output logic           out_strobe
);

    localparam int SEGW = PCW - 4;

    logic [PCW-1:0]  r_pc;
    logic [DW-1:0]   r_accu;
    logic            r_carry;
    logic [SEGW-1:0] r_seg;
    logic [DW-1:0]   r_out_data;
    logic            r_out_strobe;

    logic [PCW-1:0]  w_pc_nxt;
    logic [DW-1:0]   w_accu_nxt;
    logic            w_carry_nxt;
    logic [SEGW-1:0] w_seg_nxt;
    logic [DW-1:0]   w_out_nxt;
    logic            w_strobe_nxt;

    iclass_e         w_class;
    logic [DW-1:0]   w_rdata;
    logic [DW:0]     w_sum;
    logic [DW-1:0]   w_ldi;
    logic [SEGW-1:0] w_seg_src;
    logic            w_we;

    assign w_class = decode_class(instr);
    assign w_we    = instr_valid && (w_class == IC_STA);
    assign w_sum   = {1'b0, w_rdata} + {1'b0, r_accu};
    assign w_ldi   = {{(DW-4){instr[3]}}, instr[3:0]};

    // Segment source: low accumulator bits, zero-padded when the
    // accumulator is narrower than the segment field.
    if (DW >= SEGW) begin : g_seg_wide
        assign w_seg_src = r_accu[SEGW-1:0];
    end else begin : g_seg_narrow
        assign w_seg_src = {{(SEGW-DW){1'b0}}, r_accu};
    end

    mcpu_regfile #(
        .DW    (DW),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_raddr (instr[2:0]),
        .o_rdata (w_rdata),
        .i_we    (w_we),
        .i_waddr (instr[2:0]),
        .i_wdata (r_accu)
    );

    always_comb begin
        w_pc_nxt     = r_pc + PCW'(1);
        w_accu_nxt   = r_accu;
        w_carry_nxt  = r_carry;
        w_seg_nxt    = r_seg;
        w_out_nxt    = r_out_data;
        w_strobe_nxt = 1'b0;
        if (!instr_valid) begin
            w_pc_nxt = r_pc;
        end else begin
            case (w_class)
                IC_JCC: begin
                    if (!r_carry) begin
                        w_pc_nxt = {r_seg, instr[3:0]};
                    end
                    w_carry_nxt = 1'b0;
                end
                IC_LDI: w_accu_nxt = w_ldi;
                IC_ADD: begin
                    w_accu_nxt  = w_sum[DW-1:0];
                    w_carry_nxt = w_sum[DW];
                end
                IC_LDA: w_accu_nxt = w_rdata;
                IC_NOT: w_accu_nxt = ~r_accu;
                IC_OUT: begin
                    w_out_nxt    = r_accu;
                    w_strobe_nxt = 1'b1;
                end
                IC_SEG: w_seg_nxt = w_seg_src;
                default: ;  // STA writes the regfile; NOP only advances pc
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_accu       <= '0;
            r_carry      <= 1'b0;
            r_seg        <= '0;
            r_out_data   <= '0;
            r_out_strobe <= 1'b0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_accu       <= w_accu_nxt;
            r_carry      <= w_carry_nxt;
            r_seg        <= w_seg_nxt;
            r_out_data   <= w_out_nxt;
            r_out_strobe <= w_strobe_nxt;
        end
    end

    assign pc         = r_pc;
    assign accu       = r_accu;
    assign carry      = r_carry;
    assign out_data   = r_out_data;
    assign out_strobe = r_out_strobe;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_core_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcpu_core_p
//  Description : Self-checking bench for mcpu_core_p: directed vector table,
//                hand sequences for stall/OUT/wrap/reset, an NREGS=4 build,
//                and random instructions against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcpu_core_p;
    import mcpu_pkg::*;

    localparam int DW   = 8;
    localparam int PCW  = 8;
    localparam int NR   = 8;
    localparam int MASK = 255;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (NREGS=8)
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] instr = 6'd0;
    logic [7:0] pc, accu, out_data;
    logic       carry, out_strobe;

    // Second DUT (NREGS=4)
    logic       rst4 = 1'b1;
    logic       valid4 = 1'b0;
    logic [5:0] instr4 = 6'd0;
    logic [7:0] pc4, accu4, out_data4;
    logic       carry4, out_strobe4;

    mcpu_core_p #(.DW(DW), .PCW(PCW), .NREGS(8)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .accu(accu), .carry(carry),
        .out_data(out_data), .out_strobe(out_strobe)
    );

    mcpu_core_p #(.DW(DW), .PCW(PCW), .NREGS(4)) dut4 (
        .clk(clk), .rst(rst4), .instr(instr4), .instr_valid(valid4),
        .pc(pc4), .accu(accu4), .carry(carry4),
        .out_data(out_data4), .out_strobe(out_strobe4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [5:0] ins);
        @(negedge clk);
        rst = r; instr_valid = v; instr = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input logic r, input logic v, input logic [5:0] ins);
        @(negedge clk);
        rst4 = r; valid4 = v; instr4 = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int e_pc, input int e_accu,
                             input int e_carry, input int e_out, input int e_strobe);
        chk({tag, ".pc"},     32'(pc),         32'(e_pc));
        chk({tag, ".accu"},   32'(accu),       32'(e_accu));
        chk({tag, ".carry"},  32'(carry),      32'(e_carry));
        chk({tag, ".out"},    32'(out_data),   32'(e_out));
        chk({tag, ".strobe"}, 32'(out_strobe), 32'(e_strobe));
    endtask

    // ---------------- behavioural reference model -----------------------
    int m_pc, m_accu, m_carry, m_seg, m_out, m_strobe;
    int m_regs [NR];

    function automatic iclass_e classify(input logic [5:0] ins);
        casez (ins)
            6'b00????: return IC_JCC;
            6'b01????: return IC_LDI;
            6'b100???: return IC_ADD;
            6'b101???: return IC_STA;
            6'b110???: return IC_LDA;
            6'b111000: return IC_NOT;
            6'b111001: return IC_OUT;
            6'b111010: return IC_SEG;
            default:   return IC_NOP;
        endcase
    endfunction

    task automatic model_step(input logic r, input logic v, input logic [5:0] ins);
        int idx, rv, imm, s, npc;
        if (r) begin
            m_pc = 0; m_accu = 0; m_carry = 0; m_seg = 0; m_out = 0; m_strobe = 0;
            for (int k = 0; k < NR; k++) m_regs[k] = 0;
            return;
        end
        m_strobe = 0;
        if (!v) return;
        idx = int'(ins[2:0]);
        rv  = (idx < NR) ? m_regs[idx] : 0;
        imm = int'(ins[3:0]);
        npc = (m_pc + 1) % 256;
        case (classify(ins))
            IC_JCC: begin
                if (m_carry == 0) npc = m_seg * 16 + imm;
                m_carry = 0;
            end
            IC_LDI: m_accu = ((imm >= 8) ? imm - 16 : imm) & MASK;
            IC_ADD: begin
                s = rv + m_accu;
                m_carry = s / 256;
                m_accu  = s % 256;
            end
            IC_STA: if (idx < NR) m_regs[idx] = m_accu;
            IC_LDA: m_accu = rv;
            IC_NOT: m_accu = MASK - m_accu;
            IC_OUT: begin m_out = m_accu; m_strobe = 1; end
            IC_SEG: m_seg = m_accu % 16;
            default: ;
        endcase
        m_pc = npc;
    endtask

    // ---------------- directed vector table -----------------------------
    typedef struct {
        logic [5:0] ins;
        int         e_pc;
        int         e_accu;
        int         e_carry;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{6'b010111, 8'h01, 8'h07, 0};  // LDI 7
        vecs[1]  = '{6'b011000, 8'h02, 8'hF8, 0};  // LDI -8
        vecs[2]  = '{6'b011111, 8'h03, 8'hFF, 0};  // LDI -1
        vecs[3]  = '{6'b101010, 8'h04, 8'hFF, 0};  // STA r2
        vecs[4]  = '{6'b010001, 8'h05, 8'h01, 0};  // LDI 1
        vecs[5]  = '{6'b100010, 8'h06, 8'h00, 1};  // ADD r2 -> carry
        vecs[6]  = '{6'b000101, 8'h07, 8'h00, 0};  // JCC 5 not taken
        vecs[7]  = '{6'b000101, 8'h05, 8'h00, 0};  // JCC 5 taken
        vecs[8]  = '{6'b010011, 8'h06, 8'h03, 0};  // LDI 3
        vecs[9]  = '{6'b111010, 8'h07, 8'h03, 0};  // SEG
        vecs[10] = '{6'b001010, 8'h3A, 8'h03, 0};  // JCC A in seg 3
        vecs[11] = '{6'b000001, 8'h31, 8'h03, 0};  // JCC 1, seg kept

        step(1'b1, 1'b0, 6'd0);
        step(1'b1, 1'b0, 6'd0);
        chk_state("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, vecs[i].ins);
            chk($sformatf("vec%0d.pc", i),    32'(pc),    32'(vecs[i].e_pc));
            chk($sformatf("vec%0d.accu", i),  32'(accu),  32'(vecs[i].e_accu));
            chk($sformatf("vec%0d.carry", i), 32'(carry), 32'(vecs[i].e_carry));
            chk($sformatf("vec%0d.strobe", i), 32'(out_strobe), 32'd0);
        end

        // Stall with random instructions: everything holds
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 6'($urandom()));
            chk_state($sformatf("stall%0d", i), 8'h31, 8'h03, 0, 0, 0);
        end

        // OUT, back-to-back OUT, then strobe drops
        step(1'b0, 1'b1, 6'b010101); chk_state("ldi5",   8'h32, 8'h05, 0, 0,     0);
        step(1'b0, 1'b1, 6'b111001); chk_state("out1",   8'h33, 8'h05, 0, 8'h05, 1);
        step(1'b0, 1'b1, 6'b111001); chk_state("out2",   8'h34, 8'h05, 0, 8'h05, 1);
        step(1'b0, 1'b1, 6'b010010); chk_state("ldi2",   8'h35, 8'h02, 0, 8'h05, 0);
        step(1'b0, 1'b1, 6'b111001); chk_state("out3",   8'h36, 8'h02, 0, 8'h02, 1);
        step(1'b0, 1'b0, 6'b111001); chk_state("stallO", 8'h36, 8'h02, 0, 8'h02, 0);

        // Reach pc=FF via seg F, then wrap on NOP
        step(1'b0, 1'b1, 6'b011111); chk_state("ldim1",  8'h37, 8'hFF, 0, 8'h02, 0);
        step(1'b0, 1'b1, 6'b111010); chk_state("segF",   8'h38, 8'hFF, 0, 8'h02, 0);
        step(1'b0, 1'b1, 6'b001111); chk_state("jccF",   8'hFF, 8'hFF, 0, 8'h02, 0);
        step(1'b0, 1'b1, 6'b111011); chk_state("wrap",   8'h00, 8'hFF, 0, 8'h02, 0);
        step(1'b0, 1'b1, 6'b111000); chk_state("not",    8'h01, 8'h00, 0, 8'h02, 0);

        // Reset wins over a simultaneous STA
        step(1'b0, 1'b1, 6'b010110); chk_state("ldi6",   8'h02, 8'h06, 0, 8'h02, 0);
        step(1'b0, 1'b1, 6'b101001); chk_state("sta1",   8'h03, 8'h06, 0, 8'h02, 0);
        step(1'b1, 1'b1, 6'b101001); chk_state("rststa", 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 6'b110001); chk_state("lda1",   8'h01, 8'h00, 0, 0, 0);

        // NREGS=4 build: r6 is unimplemented and must not alias r2
        step4(1'b1, 1'b0, 6'd0);
        step4(1'b0, 1'b1, 6'b010010);                        // LDI 2
        step4(1'b0, 1'b1, 6'b101110);                        // STA r6
        step4(1'b0, 1'b1, 6'b110110);                        // LDA r6
        chk("n4.lda_r6", 32'(accu4), 32'h00);
        step4(1'b0, 1'b1, 6'b110010);                        // LDA r2
        chk("n4.lda_r2", 32'(accu4), 32'h00);
        step4(1'b0, 1'b1, 6'b010100);                        // LDI 4
        step4(1'b0, 1'b1, 6'b101000);                        // STA r0
        step4(1'b0, 1'b1, 6'b010101);                        // LDI 5
        step4(1'b0, 1'b1, 6'b100000);                        // ADD r0
        chk("n4.add_r0", 32'(accu4), 32'h09);
        step4(1'b0, 1'b1, 6'b100110);                        // ADD r6
        chk("n4.add_r6.accu",  32'(accu4),  32'h09);
        chk("n4.add_r6.carry", 32'(carry4), 32'd0);
        chk("n4.pc",           32'(pc4),    32'd9);

        // Random run against the behavioural model
        step(1'b1, 1'b0, 6'd0);
        model_step(1'b1, 1'b0, 6'd0);
        for (int i = 0; i < 600; i++) begin
            logic       r, v;
            logic [5:0] ins;
            r   = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 3) != 0);
            ins = 6'($urandom());
            step(r, v, ins);
            model_step(r, v, ins);
            chk_state($sformatf("rnd%0d", i), m_pc, m_accu, m_carry, m_out, m_strobe);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcpu_core_p.md
Name: mcpu_core_p

Overview:
- Parametrised accumulator CPU core.
- Next generation of the pin-fed 6-bit-instruction micro-CPU.
- An external host or instruction ROM presents one instruction per cycle against the exported PC.
- Adds over the previous generation:
  - data width, PC width and register count are parametrised
  - synchronous register file
  - instruction-valid stall handshake
  - segment register for full-range jumps
  - LDA and OUT instructions
- Sits under the top-level pin wrapper. The wrapper performs pin muxing; this core does none.

Parameters:
- DW, 8: accumulator, register and output data width (≥4).
- PCW, 8: program counter width (≥5).
- NREGS, 8: number of implemented registers (1..8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- instr  in  6  instruction for the current pc.
- instr_valid  in  1  high = instr executes this edge; low = stall.
- pc  out  PCW  program counter (address of the instruction expected next).
- accu  out  DW  accumulator.
- carry  out  1  carry flag.
- out_data  out  DW  value latched by OUT.
- out_strobe  out  1  one-cycle pulse when out_data updates.

Behaviour:
- **Reset.** rst is synchronous, active-high, and has priority over instr_valid. It sets pc, accu, carry, seg (PCW-4 bits), every register, out_data and out_strobe to 0.
- **Execution and stall.**
  - Single-cycle execution: an instruction sampled with instr_valid=1 at edge N has all of its effects visible after edge N.
  - With instr_valid=0, all state holds, including pc, and out_strobe goes to 0.
- **Default pc update.** pc <= pc+1, wrapping modulo 2^PCW. Only a taken JCC overrides this.
- **Register index r = instr[2:0].**
  - r ≥ NREGS reads as 0.
  - Writes to r ≥ NREGS are dropped.
- **Instruction set** (instr[5:0]):
  - 00iiii JCC: if carry=0, pc <= {seg, iiii}; otherwise pc+1. carry <= 0 in both cases.
  - 01iiii LDI: accu <= iiii sign-extended to DW. carry unchanged.
  - 100rrr ADD: {carry, accu} <= reg[r] + accu, computed at DW+1 bits; carry = bit DW of the sum.
  - 101rrr STA: reg[r] <= accu on the clock edge (no latch/combinational write). accu and carry unchanged.
  - 110rrr LDA: accu <= reg[r]. carry unchanged.
  - 111000 NOT: accu <= ~accu. carry unchanged.
  - 111001 OUT: out_data <= accu; out_strobe = 1 for exactly the following cycle.
  - 111010 SEG: seg <= accu[PCW-5:0], zero-extended if DW < PCW-4.
  - 111011 and 1111xx: NOP (pc increments only).
- **out_strobe.** Registered. It is 0 after any edge that did not execute OUT, so back-to-back OUTs hold it high continuously.
- **Simultaneous STA/ADD dependence.** A STA at edge N is visible to ADD/LDA at edge N+1. There is no same-edge forwarding requirement.
- **seg persistence.** seg persists across jumps and is only changed by SEG or rst.
- **No exceptions.** There are no illegal opcodes; all 64 encodings are defined above.

Decomposition:
- Package mcpu_pkg holds:
  - opcode constants: OP_JCC=2'b00, OP_LDI=2'b01, OP_ADD=3'b100, OP_STA=3'b101, OP_LDA=3'b110, OP_NOT=6'b111000, OP_OUT=6'b111001, OP_SEG=6'b111010
  - an instruction-class enum used by the decoder and the bench scoreboard
- One sub-module, mcpu_regfile, parametrised by DW and NREGS:
  - 1 combinational read port
  - 1 synchronous write port with enable
  - synchronous clear on rst
  - out-of-range read returns 0; out-of-range write is dropped
- Decode, ALU, pc and seg logic remain in mcpu_core_p.

Test Plan:
- **LDI sign extension.** rst 2 cycles, then LDI 7 (010111), then LDI -8 (011000) → accu=0x07 with pc=1, then accu=0xF8 with pc=2; carry=0 throughout.
- **ADD carry and JCC.**
  - Sequence: LDI -1; STA r2 (101010); LDI 1; ADD r2 (100010).
  - After ADD: accu=0x00, carry=1.
  - JCC 5 (000101) is not taken: pc increments, carry becomes 0.
  - A second JCC 5 is taken: pc=0x05.
- **Segmented jump.** LDI 3; SEG (111010); JCC 0xA (001010) with carry=0 → pc=0x3A. A later JCC 1 → pc=0x31 (seg retained).
- **Stall and OUT.**
  - instr_valid=0 for 3 cycles with random instr → pc, accu, carry, out_data unchanged; out_strobe=0.
  - Then LDI 5; OUT (111001) → out_data=0x05; out_strobe high for exactly 1 cycle.
- **Wrap, reset priority, parameter corners.**
  - From pc=0xFF, a NOP → pc=0x00.
  - rst asserted together with instr_valid=1 and STA r1 → r1 reads 0 afterwards, all outputs 0.
- **NREGS=4 build.** LDI 2; STA r6; LDA r6 → accu=0x00. ADD r6 with accu=0x09 → accu=0x09, carry=0.
